// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time, byte/half lane steering,
// sign/zero extension and misalignment detection, with valid/ready on both sides.
module lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_lsu_type,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wstrb,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                  state_q;
    logic [3:0]              type_q;
    logic [1:0]              lane_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [3:0]              mem_wstrb_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic                    is_load_c;
    logic                    is_store_c;
    logic                    misaligned_c;
    logic [3:0]              wstrb_c;
    logic [DATA_WIDTH-1:0]   wdata_c;
    logic [DATA_WIDTH-1:0]   rdata_shift_c;
    logic [DATA_WIDTH-1:0]   rsp_data_c;

    // Decode of the incoming operation (only meaningful while accepting in IDLE).
    always_comb begin
        is_load_c    = 1'b0;
        is_store_c   = 1'b0;
        misaligned_c = 1'b0;
        wstrb_c      = 4'b0000;
        wdata_c      = '0;
        case (i_lsu_type)
            OP_LB, OP_LBU: is_load_c = 1'b1;
            OP_LH, OP_LHU: begin
                is_load_c    = 1'b1;
                misaligned_c = i_addr[0];
            end
            OP_LW: begin
                is_load_c    = 1'b1;
                misaligned_c = (i_addr[1:0] != 2'b00);
            end
            OP_SB: begin
                is_store_c = 1'b1;
                wstrb_c    = 4'b0001 << i_addr[1:0];
                wdata_c    = {4{i_wr_data[7:0]}};
            end
            OP_SH: begin
                is_store_c   = 1'b1;
                misaligned_c = i_addr[0];
                wstrb_c      = 4'b0011 << i_addr[1:0];
                wdata_c      = {2{i_wr_data[15:0]}};
            end
            OP_SW: begin
                is_store_c   = 1'b1;
                misaligned_c = (i_addr[1:0] != 2'b00);
                wstrb_c      = 4'b1111;
                wdata_c      = i_wr_data;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension of the returned word; stores report zero.
    always_comb begin
        rdata_shift_c = i_mem_rdata >> {lane_q, 3'b000};
        rsp_data_c    = '0;
        case (type_q)
            OP_LB:  rsp_data_c = {{(DATA_WIDTH-8){rdata_shift_c[7]}}, rdata_shift_c[7:0]};
            OP_LBU: rsp_data_c = {{(DATA_WIDTH-8){1'b0}}, rdata_shift_c[7:0]};
            OP_LH:  rsp_data_c = {{(DATA_WIDTH-16){rdata_shift_c[15]}}, rdata_shift_c[15:0]};
            OP_LHU: rsp_data_c = {{(DATA_WIDTH-16){1'b0}}, rdata_shift_c[15:0]};
            OP_LW:  rsp_data_c = i_mem_rdata;
            default: rsp_data_c = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            type_q      <= 4'd0;
            lane_q      <= 2'b00;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        ready_q <= 1'b0;
                        type_q  <= i_lsu_type;
                        lane_q  <= i_addr[1:0];
                        if ((is_load_c || is_store_c) && !misaligned_c) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_c;
                            mem_addr_q  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wstrb_q <= wstrb_c;
                            mem_wdata_q <= wdata_c;
                            state_q     <= S_REQ;
                        end else begin
                            // NONE echoes the address; misaligned ops report an error with zero data.
                            valid_q   <= 1'b1;
                            err_q     <= misaligned_c;
                            rd_data_q <= (is_load_c || is_store_c) ? '0 : DATA_WIDTH'(i_addr);
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (i_mem_rvalid) begin
                            rd_data_q <= rsp_data_c;
                            err_q     <= 1'b0;
                            valid_q   <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        rd_data_q <= rsp_data_c;
                        err_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_err       = err_q;
    assign o_rd_data   = rd_data_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scripted memory responder, reference model and
// a result scoreboard filled at issue time and drained at the write-back handshake.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_lsu_type;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rd_data;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_lsu_type   (i_lsu_type),
        .i_addr       (i_addr),
        .i_wr_data    (i_wr_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_rd_data    (o_rd_data),
        .o_err        (o_err),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wstrb  (o_mem_wstrb),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [31:0] a);
        case (op)
            4'd2, 4'd5, 4'd7: return a[0];
            4'd3, 4'd8:       return a[1:0] != 2'b00;
            default:          return 1'b0;
        endcase
    endfunction

    // Reference result: lane picked by byte offset, extended as the op requires.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        exp_t        e;
        int          ofs;
        logic [7:0]  b;
        logic [15:0] h;
        ofs = int'(a[1:0]);
        b   = rd[ofs*8 +: 8];
        h   = (ofs >= 2) ? rd[31:16] : rd[15:0];
        e.err  = is_misaligned(op, a);
        e.data = 32'h0;
        if (!is_mem_op(op))  e.data = a;
        else if (e.err)      e.data = 32'h0;
        else begin
            case (op)
                4'd1: e.data = 32'($signed(b));
                4'd2: e.data = 32'($signed(h));
                4'd3: e.data = rd;
                4'd4: e.data = {24'h0, b};
                4'd5: e.data = {16'h0, h};
                default: e.data = 32'h0;
            endcase
        end
        return e;
    endfunction

    task automatic check_req(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic        st;
        logic [3:0]  strb;
        logic [31:0] wdat;
        st   = (op >= 4'd6);
        strb = (op == 4'd6) ? 4'(4'b0001 << a[1:0]) : (op == 4'd7) ? 4'(4'b0011 << a[1:0]) : 4'b1111;
        wdat = (op == 4'd6) ? {4{wd[7:0]}} : (op == 4'd7) ? {2{wd[15:0]}} : wd;
        check({tag, "/req"},   32'(o_mem_req), 32'd1);
        check({tag, "/maddr"}, o_mem_addr, {a[31:2], 2'b00});
        check({tag, "/we"},    32'(o_mem_we), 32'(st));
        if (st) begin
            check({tag, "/wstrb"}, 32'(o_mem_wstrb), 32'(strb));
            check({tag, "/wdata"}, o_mem_wdata, wdat);
        end
        check({tag, "/nvalid"}, 32'(o_valid), 32'd0);
    endtask

    // One complete operation: issue, scripted grant/response delays, delayed write-back.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gnt_dly, input int rv_dly, input int rdy_dly);
        exp_t e;
        exp_t got_e;
        logic mem;
        mem = is_mem_op(op) && !is_misaligned(op, a);
        @(negedge clk);
        check({tag, "/ready"}, 32'(o_ready), 32'd1);
        i_valid    = 1'b1;
        i_lsu_type = op;
        i_addr     = a;
        i_wr_data  = wd;
        sb_q.push_back(model(op, a, rd));
        @(negedge clk);
        i_valid = 1'b0;
        check({tag, "/busy"}, 32'(o_ready), 32'd0);
        if (mem) begin
            repeat (gnt_dly) begin
                check_req(tag, op, a, wd);
                @(negedge clk);
            end
            check_req(tag, op, a, wd);
            i_mem_gnt = 1'b1;
            if (rv_dly == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rd;
            end
            @(negedge clk);
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (rv_dly > 0) begin
                repeat (rv_dly - 1) begin
                    check({tag, "/wait_req"},   32'(o_mem_req), 32'd0);
                    check({tag, "/wait_valid"}, 32'(o_valid), 32'd0);
                    @(negedge clk);
                end
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rd;
                @(negedge clk);
                i_mem_rvalid = 1'b0;
            end
        end else begin
            check({tag, "/noreq"}, 32'(o_mem_req), 32'd0);
        end
        e = sb_q[0];
        check({tag, "/valid"}, 32'(o_valid), 32'd1);
        repeat (rdy_dly) begin
            check({tag, "/hold_data"}, o_rd_data, e.data);
            check({tag, "/hold_err"},  32'(o_err), 32'(e.err));
            check({tag, "/hold_rdy"},  32'(o_ready), 32'd0);
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(o_valid), 32'd1);
        end
        if (sb_q.size() == 0) begin
            check({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            got_e = sb_q.pop_front();
            check({tag, "/data"}, o_rd_data, got_e.data);
            check({tag, "/err"},  32'(o_err), 32'(got_e.err));
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({tag, "/released"}, 32'(o_valid), 32'd0);
        check({tag, "/idle"},     32'(o_ready), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        i_valid      = 1'b0;
        i_lsu_type   = 4'd0;
        i_addr       = 32'h0;
        i_wr_data    = 32'h0;
        i_ready      = 1'b0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        check("rst/ready", 32'(o_ready), 32'd1);
        check("rst/valid", 32'(o_valid), 32'd0);
        check("rst/err",   32'(o_err), 32'd0);
        check("rst/rdata", o_rd_data, 32'h0);
        check("rst/req",   32'(o_mem_req), 32'd0);
        check("rst/we",    32'(o_mem_we), 32'd0);
        check("rst/maddr", o_mem_addr, 32'h0);
        check("rst/wstrb", 32'(o_mem_wstrb), 32'd0);
        check("rst/wdata", o_mem_wdata, 32'h0);
        rst = 1'b0;

        run_op("lb_neg",    4'd1, 32'h0000_0103, 32'h0,         32'h80FF_FF00, 0, 0, 0);
        run_op("sh_hi",     4'd7, 32'h0000_0202, 32'h0000_1234, 32'hDEAD_BEEF, 0, 1, 0);
        run_op("lw_mis",    4'd3, 32'h0000_0006, 32'h0,         32'h0,         0, 0, 0);
        run_op("lhu_slow",  4'd5, 32'h0000_0002, 32'h0,         32'hABCD_0000, 3, 2, 0);
        run_op("none_hold", 4'd0, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 4);
        run_op("lh_neg",    4'd2, 32'h0000_0010, 32'h0,         32'h1111_8001, 1, 0, 1);
        run_op("lbu_b1",    4'd4, 32'h0000_0021, 32'h0,         32'h0000_F000, 0, 3, 0);
        run_op("lb_pos",    4'd1, 32'h0000_0030, 32'h0,         32'hFFFF_FF7F, 0, 0, 0);
        run_op("lw_ok",     4'd3, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 2, 0, 2);
        run_op("sb_b3",     4'd6, 32'h0000_0053, 32'h0000_00AB, 32'h5555_5555, 0, 0, 0);
        run_op("sw_ok",     4'd8, 32'h0000_0060, 32'hCAFE_F00D, 32'h0,         1, 1, 0);
        run_op("sh_lo",     4'd7, 32'h0000_0070, 32'h9876_5432, 32'h0,         0, 0, 0);
        run_op("sh_mis",    4'd7, 32'h0000_0071, 32'h0000_1234, 32'h0,         0, 0, 0);
        run_op("lhu_mis",   4'd5, 32'h0000_0083, 32'h0,         32'h0,         0, 0, 1);
        run_op("sw_mis",    4'd8, 32'h0000_0092, 32'h1234_5678, 32'h0,         0, 0, 0);
        run_op("op_undef",  4'd15, 32'hA5A5_0003, 32'h0,        32'h0,         0, 0, 0);

        // Reset while waiting for read data; a late response must be dropped.
        @(negedge clk);
        i_valid = 1'b1; i_lsu_type = 4'd3; i_addr = 32'h0000_0100;
        @(negedge clk);
        i_valid = 1'b0; i_mem_gnt = 1'b1;
        @(negedge clk);
        i_mem_gnt = 1'b0;
        check("rstw/pre_req", 32'(o_mem_req), 32'd0);
        check("rstw/pre_rdy", 32'(o_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw/ready", 32'(o_ready), 32'd1);
        check("rstw/req",   32'(o_mem_req), 32'd0);
        check("rstw/valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h7777_7777;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        repeat (3) begin
            check("rstw/stray_valid", 32'(o_valid), 32'd0);
            check("rstw/stray_rdy",   32'(o_ready), 32'd1);
            @(negedge clk);
        end

        // Reset while the request is still outstanding drops it immediately.
        i_valid = 1'b1; i_lsu_type = 4'd8; i_addr = 32'h0000_0204; i_wr_data = 32'h1;
        @(negedge clk);
        i_valid = 1'b0;
        check("rstr/pre_req", 32'(o_mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rstr/req",   32'(o_mem_req), 32'd0);
        check("rstr/maddr", o_mem_addr, 32'h0);
        check("rstr/ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_op("post_rst", 4'd2, 32'h0000_0302, 32'h0, 32'h7FFF_0000, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
